// File: rtl/lcd_text_pkg.sv
// ============================================================================
// Module  : lcd_text_pkg
// Brief   : Shared constants, state encoding and helpers for lcd_text_writer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package lcd_text_pkg;

    localparam int NUM_CELLS = 32;
    localparam int LINE_LEN  = 16;

    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;

    localparam logic [7:0] BLANK_DEF   = 8'h20;
    localparam logic [7:0] BS_CODE_DEF = 8'h08;
    localparam logic [7:0] NL_CODE_DEF = 8'h0D;
    localparam logic [7:0] FF_CODE_DEF = 8'h0C;

    typedef enum logic [1:0] {
        CLR_ALL  = 2'd0,
        CLR_LINE = 2'd1,
        IDLE     = 2'd2
    } state_t;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= PRINT_LO) && (c <= PRINT_HI);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_text_writer.sv
// ============================================================================
// Module  : lcd_text_writer
// Brief   : Byte-stream to 2x16 character-LCD display-RAM writer with cursor,
//           backspace, newline and clear-screen handling.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lcd_text_writer
    import lcd_text_pkg::*;
#(
    parameter logic [7:0] BLANK   = BLANK_DEF,
    parameter logic [7:0] BS_CODE = BS_CODE_DEF,
    parameter logic [7:0] NL_CODE = NL_CODE_DEF,
    parameter logic [7:0] FF_CODE = FF_CODE_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] char_in,
    input  logic       char_valid,
    output logic       char_ready,
    output logic [7:0] lcd_din,
    output logic       lcd_w,
    output logic [4:0] lcd_wadd,
    output logic [4:0] cursor,
    output logic       busy
);

    state_t     r_state;
    logic [4:0] r_cnt;

    state_t     w_state;
    logic [4:0] w_cnt;
    logic [4:0] w_cursor;
    logic [4:0] w_wadd;
    logic [7:0] w_din;
    logic       w_w;
    logic       w_busy;
    logic       w_ready;
    logic       w_xfer;

    assign w_xfer = char_valid & char_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= CLR_ALL;
            r_cnt      <= 5'd0;
            cursor     <= 5'd0;
            lcd_w      <= 1'b0;
            lcd_wadd   <= 5'd0;
            lcd_din    <= BLANK;
            busy       <= 1'b1;
            char_ready <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            cursor     <= w_cursor;
            lcd_w      <= w_w;
            lcd_wadd   <= w_wadd;
            lcd_din    <= w_din;
            busy       <= w_busy;
            char_ready <= w_ready;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_cursor = cursor;
        w_w      = 1'b0;
        w_wadd   = lcd_wadd;
        w_din    = lcd_din;
        w_busy   = busy;

        case (r_state)
            CLR_ALL: begin
                w_w    = 1'b1;
                w_wadd = r_cnt;
                w_din  = BLANK;
                w_cnt  = r_cnt + 5'd1;
                if (r_cnt == 5'(NUM_CELLS - 1)) begin
                    w_state  = IDLE;
                    w_cursor = 5'd0;
                    w_busy   = 1'b0;
                end
            end

            CLR_LINE: begin
                w_w    = 1'b1;
                w_wadd = r_cnt;
                w_din  = BLANK;
                w_cnt  = r_cnt + 5'd1;
                // A line never crosses bit 4, so the line base is r_cnt[4].
                if (r_cnt[3:0] == 4'hF) begin
                    w_state  = IDLE;
                    w_cursor = {r_cnt[4], 4'b0000};
                    w_busy   = 1'b0;
                end
            end

            IDLE: begin
                if (w_xfer) begin
                    if (char_in == FF_CODE) begin
                        w_state = CLR_ALL;
                        w_cnt   = 5'd0;
                        w_busy  = 1'b1;
                    end else if (char_in == NL_CODE) begin
                        w_state = CLR_LINE;
                        w_cnt   = {~cursor[4], 4'b0000};
                        w_busy  = 1'b1;
                    end else if (char_in == BS_CODE) begin
                        if (cursor != 5'd0) begin
                            w_cursor = cursor - 5'd1;
                            w_w      = 1'b1;
                            w_wadd   = cursor - 5'd1;
                            w_din    = BLANK;
                        end
                    end else if (is_printable(char_in)) begin
                        w_w      = 1'b1;
                        w_wadd   = cursor;
                        w_din    = char_in;
                        w_cursor = cursor + 5'd1;
                    end
                end
            end

            default: begin
                w_state = CLR_ALL;
                w_cnt   = 5'd0;
                w_busy  = 1'b1;
            end
        endcase

        w_ready = (w_state == IDLE);
    end

endmodule

`default_nettype wire

// File: tb/tb_lcd_text_writer.sv
// ============================================================================
// Module  : tb_lcd_text_writer
// Brief   : Self-checking bench for lcd_text_writer against a display model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lcd_text_writer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] char_in = 8'h00;
    logic       char_valid = 1'b0;
    logic       char_ready;
    logic [7:0] lcd_din;
    logic       lcd_w;
    logic [4:0] lcd_wadd;
    logic [4:0] cursor;
    logic       busy;

    lcd_text_writer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .lcd_din    (lcd_din),
        .lcd_w      (lcd_w),
        .lcd_wadd   (lcd_wadd),
        .cursor     (cursor),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         c;
        logic [4:0] a;
        logic [7:0] d;
    } wr_t;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    wr_t         obs_q[$];
    logic [12:0] exp_q[$];
    logic [4:0]  m_cur = 5'd0;
    wr_t         mon_w;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && lcd_w) begin
            mon_w.c = cyc;
            mon_w.a = lcd_wadd;
            mon_w.d = lcd_din;
            obs_q.push_back(mon_w);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Display-level model: what cells a byte should rewrite and where the cursor lands.
    task automatic model(input logic [7:0] b);
        int base;
        if (b == 8'h0C) begin
            for (int i = 0; i < 32; i++) exp_q.push_back({5'(i), 8'h20});
            m_cur = 5'd0;
        end else if (b == 8'h0D) begin
            base = (m_cur < 16) ? 16 : 0;
            for (int i = 0; i < 16; i++) exp_q.push_back({5'(base + i), 8'h20});
            m_cur = 5'(base);
        end else if (b == 8'h08) begin
            if (m_cur > 0) begin
                m_cur = m_cur - 5'd1;
                exp_q.push_back({m_cur, 8'h20});
            end
        end else if (b >= 8'h20 && b <= 8'h7E) begin
            exp_q.push_back({m_cur, b});
            m_cur = m_cur + 5'd1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        while (!char_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("send_ready", {31'd0, char_ready}, 32'd1);
        char_in    = b;
        char_valid = 1'b1;
        @(posedge clk); #1;
        char_valid = 1'b0;
        char_in    = $urandom();
        model(b);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (!char_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!char_ready) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic compare(input string tag, input bit consec);
        int n;
        @(posedge clk); #1;
        chk({tag, "_nwr"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_addr"}, {27'd0, obs_q[i].a}, {27'd0, exp_q[i][12:8]});
            chk({tag, "_din"},  {24'd0, obs_q[i].d}, {24'd0, exp_q[i][7:0]});
            if (consec && i > 0) chk({tag, "_gap"}, obs_q[i].c - obs_q[i-1].c, 32'd1);
        end
        chk({tag, "_cursor"}, {27'd0, cursor}, {27'd0, m_cur});
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_w"},     {31'd0, lcd_w}, 32'd0);
        chk({tag, "_wadd"},  {27'd0, lcd_wadd}, 32'd0);
        chk({tag, "_din"},   {24'd0, lcd_din}, 32'h20);
        chk({tag, "_cur"},   {27'd0, cursor}, 32'd0);
        chk({tag, "_ready"}, {31'd0, char_ready}, 32'd0);
        chk({tag, "_busy"},  {31'd0, busy}, 32'd1);
    endtask

    task automatic clear_and_check(input string tag);
        int n;
        send(8'h0C);
        wait_idle(n);
        compare(tag, 1'b1);
    endtask

    initial begin
        int     n;
        logic [7:0] b;
        logic [7:0] hello [5];
        hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};

        // Reset and power-on clear
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) exp_q.push_back({5'(i), 8'h20});
        wait_idle(n);
        chk("rst_clr_len", n, 32'd32);
        chk("rst_ready", {31'd0, char_ready}, 32'd1);
        compare("rst_clr", 1'b1);

        // HELLO back-to-back
        for (int i = 0; i < 5; i++) send(hello[i]);
        compare("hello", 1'b1);

        // Cursor wrap after 32 characters
        clear_and_check("ff1");
        for (int i = 0; i < 32; i++) send(8'($urandom_range(32'h20, 32'h7E)));
        send(8'h58);
        compare("wrap", 1'b1);
        chk("wrap_cur1", {27'd0, cursor}, 32'd1);

        // Backspace at cursor 5 and at 0
        clear_and_check("ff2");
        for (int i = 0; i < 5; i++) send(8'h41 + 8'(i));
        compare("bs_pre", 1'b1);
        send(8'h08);
        compare("bs5", 1'b0);
        clear_and_check("ff3");
        send(8'h08);
        compare("bs0", 1'b0);

        // Newline from cursor 7, then back to line 1
        for (int i = 0; i < 7; i++) send(8'h61 + 8'(i));
        compare("nl_pre", 1'b1);
        send(8'h0D);
        wait_idle(n);
        chk("nl1_ready_low", n, 32'd16);
        compare("nl1", 1'b1);
        send(8'h0D);
        wait_idle(n);
        chk("nl2_ready_low", n, 32'd16);
        compare("nl2", 1'b1);

        // Reset in the middle of a clear-screen
        for (int i = 0; i < 3; i++) send(8'h30 + 8'(i));
        compare("mid_pre", 1'b1);
        send(8'h0C);
        n = 0;
        while (obs_q.size() < 10 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("mid_reach10", obs_q.size(), 32'd10);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        obs_q.delete();
        exp_q.delete();
        for (int i = 0; i < 32; i++) exp_q.push_back({5'(i), 8'h20});
        m_cur = 5'd0;
        wait_idle(n);
        chk("midrst_clr_len", n, 32'd32);
        compare("midrst_clr", 1'b1);

        for (int i = 0; i < 4; i++) send(8'h50 + 8'(i));
        send(8'h07);
        compare("ctl07", 1'b0);

        // Randomized mixed stream
        for (int k = 0; k < 400; k++) begin
            n = $urandom_range(0, 99);
            if (n < 70)      b = 8'($urandom_range(32'h20, 32'h7E));
            else if (n < 80) b = 8'h08;
            else if (n < 85) b = 8'h0D;
            else if (n < 87) b = 8'h0C;
            else             b = 8'($urandom());
            send(b);
            if (b == 8'h0D || b == 8'h0C) wait_idle(n);
            if (k % 50 == 49) compare("rand", 1'b0);
        end
        wait_idle(n);
        compare("rand_end", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
